spi_seq_detector: RTL and testbench
===================================

Name: spi_seq_detector

Overview:
- Parametrised successor to the fixed 4-state SPI bit-stream FSM.
- Consumes one serial bit per qualifying strobe (`i_Valid`) from the SPI receive path.
- Compares the last W bits against a runtime-loadable pattern. Supports overlapping or non-overlapping detection.
- Reports fill state, a one-cycle match pulse and a saturating match counter. It sits between the SPI slave bit output and the status/monitor logic.

Parameters:
- W, 8, pattern length in bits; legal range 2..32.
- CNT_W, 8, match-counter width; legal range 1..32.
- ST_W, $clog2(W+1), width of the fill-state output. Derived; do not override.

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Rst  in  1  asynchronous active-low reset.
- i_Valid  in  1  the bit on `i_Data` is consumed this cycle.
- i_Data  in  1  serial bit, SPI mode 0, sampled on the rising edge.
- i_Load  in  1  load `i_Pattern` and restart detection.
- i_Pattern  in  W  pattern; bit W-1 is the first bit received.
- i_Mode  in  1  0 = overlapping, 1 = non-overlapping.
- i_Clr  in  1  synchronous clear of the match counter and the sticky saturation flag.
- o_State  out  ST_W  bits held since last restart, saturating at W.
- o_Match  out  1  one-cycle pulse on detection.
- o_Count  out  CNT_W  number of matches, saturating.
- o_Sat  out  1  sticky; set when a match occurs with `o_Count` already at all-ones.

Behaviour:
- Reset (`i_Rst` = 0, async): the following are all 0 and stay 0 while reset is held:
  - history register `hist[W-1:0]` and the pattern register;
  - `o_State`, `o_Match`, `o_Count`, `o_Sat`.
- Reset at any point mid-stream discards the partial history.
- Priority per cycle: `i_Load` > `i_Valid`.
- Load cycle (`i_Load` = 1):
  - pattern register <= `i_Pattern`; `hist` <= 0; `o_State` <= 0; `o_Match` <= 0.
  - A coincident `i_Valid` bit is discarded.
  - `o_Count`/`o_Sat` are unaffected.
- Bit cycle (`i_Valid` = 1, `i_Load` = 0):
  - `nh = {hist[W-2:0], i_Data}`; `ns = min(o_State+1, W)`.
  - Hit when `ns == W` and `nh == pattern`.
  - No hit: `hist` <= `nh`, `o_State` <= `ns`.
  - Hit, `i_Mode` = 0 (overlap): `hist` <= `nh`, `o_State` <= W. Back-to-back hits are possible.
  - Hit, `i_Mode` = 1 (non-overlap): `hist` <= 0, `o_State` <= 0. At least W further bits are needed for the next hit.
- `o_Match` timing:
  - Registered; high for exactly the one cycle following the hit's clock edge.
  - Low on every cycle where the hit condition is false, including `i_Valid` = 0 idle cycles.
- Counter, on a hit:
  - If `o_Count` != all-ones, `o_Count` <= `o_Count`+1.
  - Otherwise `o_Count` holds and `o_Sat` <= 1.
  - Never wraps.
- `i_Clr`:
  - `o_Count` <= 0, `o_Sat` <= 0.
  - If a hit occurs in the same cycle, clear wins: count = 0, hit not counted. `o_Match` still pulses.
- `i_Valid` = 0: all state holds, regardless of `i_Data`.
- `i_Mode` is sampled per bit cycle. Changing it mid-stream affects only subsequent hits.
- The pattern register changes only on `i_Load`. `i_Pattern` is ignored otherwise.
- Latency: the bit on the completing edge produces `o_Match`/`o_Count` updates visible one cycle later, i.e. at registered outputs after that edge.

Decomposition:
- Package `spi_pkg`:
  - `localparam` mode encodings `MODE_OVERLAP` = 1'b0, `MODE_NONOVERLAP` = 1'b1;
  - default W/CNT_W constants;
  - a `$clog2`-based width helper.
- One sub-module: `sat_counter` (params CNT_W; ports `i_Clk`, `i_Rst`, `i_Inc`, `i_Clr`, `o_Count`, `o_Sat`). It implements the saturating counter with clear-wins priority.
- The shift/compare/fill logic stays in `spi_seq_detector`.

Test Plan:
- W=4, load 4'b1011, `i_Mode`=0, stream 1,0,1,1,0,1,1 (`i_Valid` every cycle).
  -> `o_Match` pulses after the 4th and 7th bits; `o_Count`=2; `o_State` ramps 1,2,3,4 then stays 4.
- Same stream, `i_Mode`=1.
  -> single pulse after the 4th bit; `o_State` returns to 0 then reads 3 after bit 7; `o_Count`=1.
- W=4, pattern 4'b1011, stream 1,0,1,1 with `i_Valid` low for 3 cycles between each bit and `i_Data` toggling while invalid.
  -> exactly one match; `o_State` changes only on valid cycles.
- CNT_W=2, pattern 4'b1111, `i_Mode`=0, eight consecutive 1s.
  -> matches at bits 4..8 (5 pulses); `o_Count` = 1,2,3,3,3; `o_Sat` set on the 4th match.
  -> then `i_Clr` -> `o_Count`=0, `o_Sat`=0.
- Load/reset collisions:
  - Pattern 4'b1011, send 1,0,1; assert `i_Load` with new pattern 4'b0000 coincident with a valid 1.
    -> `o_State`=0, bit discarded; four valid 0s -> one match.
  - Drop `i_Rst` low mid-stream, asynchronously between edges.
    -> all outputs 0 immediately; pattern register 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI sequence detector slice.
package spi_pkg;

    localparam logic MODE_OVERLAP    = 1'b0;
    localparam logic MODE_NONOVERLAP = 1'b1;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_CNT_W = 8;

    // Bits needed to hold a fill level running from 0 up to and including w.
    function automatic int stateWidth(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating match counter with a sticky overflow flag; a clear beats a
// coincident increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Inc,
    input  logic             i_Clr,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Sat
);

    logic [CNT_W-1:0] r_Count;
    logic             r_Sat;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Count <= '0;
            r_Sat   <= 1'b0;
        end else if (i_Clr) begin
            r_Count <= '0;
            r_Sat   <= 1'b0;
        end else if (i_Inc) begin
            // At all-ones the count holds and the overflow is remembered instead.
            if (r_Count == {CNT_W{1'b1}}) begin
                r_Sat <= 1'b1;
            end else begin
                r_Count <= r_Count + CNT_W'(1);
            end
        end
    end

    assign o_Count = r_Count;
    assign o_Sat   = r_Sat;

endmodule

// File: rtl/spi_seq_detector.sv
// Serial pattern detector for the SPI receive path: shifts in one bit per
// valid strobe and flags when the last W bits equal a loadable pattern.
module spi_seq_detector
    import spi_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int ST_W  = stateWidth(W)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Valid,
    input  logic             i_Data,
    input  logic             i_Load,
    input  logic [W-1:0]     i_Pattern,
    input  logic             i_Mode,
    input  logic             i_Clr,
    output logic [ST_W-1:0]  o_State,
    output logic             o_Match,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Sat
);

    logic [W-1:0]    r_Hist;
    logic [W-1:0]    r_Pattern;
    logic [ST_W-1:0] r_State;
    logic            r_Match;

    logic [W-1:0]    w_NextHist;
    logic [ST_W-1:0] w_NextState;
    logic            w_Hit;

    assign w_NextHist  = {r_Hist[W-2:0], i_Data};
    assign w_NextState = (r_State == ST_W'(W)) ? r_State : r_State + ST_W'(1);

    // A hit needs a full window of fresh bits; a load cycle never hits.
    assign w_Hit = i_Valid && !i_Load
                && (w_NextState == ST_W'(W))
                && (w_NextHist == r_Pattern);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Hist    <= '0;
            r_Pattern <= '0;
            r_State   <= '0;
            r_Match   <= 1'b0;
        end else if (i_Load) begin
            r_Pattern <= i_Pattern;
            r_Hist    <= '0;
            r_State   <= '0;
            r_Match   <= 1'b0;
        end else begin
            r_Match <= w_Hit;
            if (i_Valid) begin
                // Non-overlapping mode starts a fresh window after every hit.
                if (w_Hit && (i_Mode == MODE_NONOVERLAP)) begin
                    r_Hist  <= '0;
                    r_State <= '0;
                end else begin
                    r_Hist  <= w_NextHist;
                    r_State <= w_NextState;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Inc   (w_Hit),
        .i_Clr   (i_Clr),
        .o_Count (o_Count),
        .o_Sat   (o_Sat)
    );

    assign o_State = r_State;
    assign o_Match = r_Match;

endmodule

// File: tb/tb_spi_seq_detector.sv
// Directed bench for spi_seq_detector at W=4, CNT_W=2 with hand-computed expectations.
module tb_spi_seq_detector;

    localparam int W     = 4;
    localparam int CNT_W = 2;
    localparam int ST_W  = $clog2(W + 1);

    logic             i_Clk = 1'b0;
    logic             i_Rst = 1'b0;
    logic             i_Valid = 1'b0;
    logic             i_Data = 1'b0;
    logic             i_Load = 1'b0;
    logic [W-1:0]     i_Pattern = '0;
    logic             i_Mode = 1'b0;
    logic             i_Clr = 1'b0;
    logic [ST_W-1:0]  o_State;
    logic             o_Match;
    logic [CNT_W-1:0] o_Count;
    logic             o_Sat;

    int checks = 0;
    int errors = 0;

    spi_seq_detector #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Valid   (i_Valid),
        .i_Data    (i_Data),
        .i_Load    (i_Load),
        .i_Pattern (i_Pattern),
        .i_Mode    (i_Mode),
        .i_Clr     (i_Clr),
        .o_State   (o_State),
        .o_Match   (o_Match),
        .o_Count   (o_Count),
        .o_Sat     (o_Sat)
    );

    always #5 i_Clk = ~i_Clk;

    // Drive one valid bit for a single cycle; outputs are stable when this returns.
    task automatic sendBit(input logic d, input logic clr);
        @(negedge i_Clk);
        i_Valid = 1'b1;
        i_Data  = d;
        i_Clr   = clr;
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        i_Clr   = 1'b0;
    endtask

    task automatic idleCycle(input logic d);
        @(negedge i_Clk);
        i_Valid = 1'b0;
        i_Data  = d;
        @(posedge i_Clk);
        #1;
    endtask

    // Load a pattern and clear the counter in the same cycle.
    task automatic loadPattern(input logic [W-1:0] p);
        @(negedge i_Clk);
        i_Load    = 1'b1;
        i_Pattern = p;
        i_Clr     = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Load = 1'b0;
        i_Clr  = 1'b0;
    endtask

    task automatic test_reset();
        i_Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_Clk);
            i_Valid = 1'b1;
            i_Data  = i[0];
            @(posedge i_Clk);
            #1;
            checks++;
            if ({o_State, o_Match, o_Count, o_Sat} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_hold: got state=%0d match=%0b count=%0d sat=%0b, want all 0",
                         o_State, o_Match, o_Count, o_Sat);
            end
        end
        @(negedge i_Clk);
        i_Valid = 1'b0;
        i_Rst   = 1'b1;
    endtask

    task automatic test_overlap();
        logic stream[7] = '{1, 0, 1, 1, 0, 1, 1};
        int   expState[7] = '{1, 2, 3, 4, 4, 4, 4};
        logic expMatch[7] = '{0, 0, 0, 1, 0, 0, 1};
        i_Mode = 1'b0;
        loadPattern(4'b1011);
        for (int i = 0; i < 7; i++) begin
            sendBit(stream[i], 1'b0);
            checks++;
            if (o_State !== ST_W'(expState[i]) || o_Match !== expMatch[i]) begin
                errors++;
                $display("[TB] FAIL overlap_bit%0d: got state=%0d match=%0b, want state=%0d match=%0b",
                         i + 1, o_State, o_Match, expState[i], expMatch[i]);
            end
        end
        checks++;
        if (o_Count !== 2'd2) begin
            errors++;
            $display("[TB] FAIL overlap_count: got %0d, want 2", o_Count);
        end
    endtask

    task automatic test_nonoverlap();
        logic stream[7] = '{1, 0, 1, 1, 0, 1, 1};
        int   expState[7] = '{1, 2, 3, 0, 1, 2, 3};
        logic expMatch[7] = '{0, 0, 0, 1, 0, 0, 0};
        i_Mode = 1'b1;
        loadPattern(4'b1011);
        for (int i = 0; i < 7; i++) begin
            sendBit(stream[i], 1'b0);
            checks++;
            if (o_State !== ST_W'(expState[i]) || o_Match !== expMatch[i]) begin
                errors++;
                $display("[TB] FAIL nonoverlap_bit%0d: got state=%0d match=%0b, want state=%0d match=%0b",
                         i + 1, o_State, o_Match, expState[i], expMatch[i]);
            end
        end
        checks++;
        if (o_Count !== 2'd1) begin
            errors++;
            $display("[TB] FAIL nonoverlap_count: got %0d, want 1", o_Count);
        end
        i_Mode = 1'b0;
    endtask

    task automatic test_valid_gaps();
        logic stream[4] = '{1, 0, 1, 1};
        loadPattern(4'b1011);
        for (int i = 0; i < 4; i++) begin
            sendBit(stream[i], 1'b0);
            checks++;
            if (o_State !== ST_W'(i + 1) || o_Match !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL gaps_bit%0d: got state=%0d match=%0b, want state=%0d match=%0b",
                         i + 1, o_State, o_Match, i + 1, (i == 3));
            end
            for (int g = 0; g < 3; g++) begin
                idleCycle(g[0] ^ stream[i] ^ 1'b1);
                checks++;
                if (o_State !== ST_W'(i + 1) || o_Match !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gaps_idle%0d_%0d: got state=%0d match=%0b, want state=%0d match=0",
                             i + 1, g, o_State, o_Match, i + 1);
                end
            end
        end
        checks++;
        if (o_Count !== 2'd1) begin
            errors++;
            $display("[TB] FAIL gaps_count: got %0d, want 1", o_Count);
        end
    endtask

    task automatic test_saturation();
        int   expCount[8] = '{0, 0, 0, 1, 2, 3, 3, 3};
        logic expSat[8]   = '{0, 0, 0, 0, 0, 0, 1, 1};
        logic expMatch[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        i_Mode = 1'b0;
        loadPattern(4'b1111);
        for (int i = 0; i < 8; i++) begin
            sendBit(1'b1, 1'b0);
            checks++;
            if (o_Match !== expMatch[i] || o_Count !== CNT_W'(expCount[i]) || o_Sat !== expSat[i]) begin
                errors++;
                $display("[TB] FAIL sat_bit%0d: got match=%0b count=%0d sat=%0b, want match=%0b count=%0d sat=%0b",
                         i + 1, o_Match, o_Count, o_Sat, expMatch[i], expCount[i], expSat[i]);
            end
        end
        @(negedge i_Clk);
        i_Clr = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Clr = 1'b0;
        checks++;
        if (o_Count !== 2'd0 || o_Sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_clear: got count=%0d sat=%0b, want count=0 sat=0", o_Count, o_Sat);
        end
        // Hit coincident with clear: the pulse still appears but is not counted.
        sendBit(1'b1, 1'b1);
        checks++;
        if (o_Match !== 1'b1 || o_Count !== 2'd0 || o_Sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_wins: got match=%0b count=%0d sat=%0b, want match=1 count=0 sat=0",
                     o_Match, o_Count, o_Sat);
        end
    endtask

    task automatic test_load_collision();
        loadPattern(4'b1011);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        @(negedge i_Clk);
        i_Load    = 1'b1;
        i_Pattern = 4'b0000;
        i_Valid   = 1'b1;
        i_Data    = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Load  = 1'b0;
        i_Valid = 1'b0;
        checks++;
        if (o_State !== '0 || o_Match !== 1'b0 || o_Count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL load_collision: got state=%0d match=%0b count=%0d, want 0/0/0",
                     o_State, o_Match, o_Count);
        end
        // The pattern input must be ignored outside load cycles.
        i_Pattern = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            sendBit(1'b0, 1'b0);
            checks++;
            if (o_State !== ST_W'(i + 1) || o_Match !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL load_zero_bit%0d: got state=%0d match=%0b, want state=%0d match=%0b",
                         i + 1, o_State, o_Match, i + 1, (i == 3));
            end
        end
        checks++;
        if (o_Count !== 2'd1) begin
            errors++;
            $display("[TB] FAIL load_count: got %0d, want 1", o_Count);
        end
    endtask

    task automatic test_async_reset();
        loadPattern(4'b1011);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0);
        checks++;
        if (o_Match !== 1'b1 || o_Count !== 2'd1) begin
            errors++;
            $display("[TB] FAIL prereset_match: got match=%0b count=%0d, want 1/1", o_Match, o_Count);
        end
        #1;
        i_Rst = 1'b0;
        #1;
        checks++;
        if ({o_State, o_Match, o_Count, o_Sat} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got state=%0d match=%0b count=%0d sat=%0b, want all 0",
                     o_State, o_Match, o_Count, o_Sat);
        end
        @(negedge i_Clk);
        i_Rst = 1'b1;
        // With the pattern register reset to zero, four zeros must match.
        for (int i = 0; i < 4; i++) begin
            sendBit(1'b0, 1'b0);
            checks++;
            if (o_State !== ST_W'(i + 1) || o_Match !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL postreset_bit%0d: got state=%0d match=%0b, want state=%0d match=%0b",
                         i + 1, o_State, o_Match, i + 1, (i == 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_valid_gaps();
        test_saturation();
        test_load_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
